// File: rtl/lcd_mon_pkg.sv
// Shared types and constants for the character-LCD bus monitor.
// Command encodings follow the HD44780 instruction set as used by the display writer.
package lcd_mon_pkg;

   typedef enum logic [1:0] {
      StInit8,
      StNibHi,
      StNibLo
   } state_e;

   localparam logic [7:0] CLEAR      = 8'h01;
   localparam logic [7:0] HOME       = 8'h02;
   localparam logic [7:0] SETADDR_L1 = 8'h80;
   localparam logic [7:0] SETADDR_L2 = 8'hC0;
   localparam logic [7:0] SPACE      = 8'h20;

   localparam int unsigned NumChars = 32;

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizers for the LCD bus plus LCDE falling-edge detection.
// rs/rw/dat come from the same synchronized sample that reveals the fall.
module lcd_bus_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [3:0] lcd_dat,
   output logic       strobe,
   output logic       rs,
   output logic       rw,
   output logic [3:0] dat
);

   // Bit order: {e, rs, rw, dat[3:0]}
   logic [6:0] meta_q, meta_d;
   logic [6:0] sync_q, sync_d;
   logic       e_prev_q, e_prev_d;

   always_comb begin
      meta_d   = {lcd_e, lcd_rs, lcd_rw, lcd_dat};
      sync_d   = meta_q;
      e_prev_d = sync_q[6];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= '0;
         sync_q   <= '0;
         e_prev_q <= 1'b0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         e_prev_q <= e_prev_d;
      end
   end

   assign strobe = e_prev_q & ~sync_q[6];
   assign rs     = sync_q[5];
   assign rw     = sync_q[4];
   assign dat    = sync_q[3:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for the 4-bit character-LCD bus: rebuilds the 32-char screen image
// from nibble traffic and reports each assembled command/data byte.
module lcd_bus_monitor
   import lcd_mon_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic         CCLK,
   input  logic         rst_n,
   input  logic         LCDE,
   input  logic         LCDRS,
   input  logic         LCDRW,
   input  logic [3:0]   LCDDAT,
   output logic [255:0] strdata,
   output logic         byte_valid,
   output logic [7:0]   byte_out,
   output logic         byte_rs,
   output logic [4:0]   ddram_addr,
   output logic         init_done,
   output logic         rd_seen
);

   localparam int unsigned CntWRaw = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CntW    = (CntWRaw < 1) ? 1 : CntWRaw;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

   logic       strobe, s_rs, s_rw;
   logic [3:0] s_dat;
   logic       bus_wr, timeout;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      hi_q, hi_d;
   logic            hi_rs_q, hi_rs_d;
   logic [255:0]    scr_q, scr_d;
   logic [4:0]      addr_q, addr_d;
   logic            bv_q, bv_d;
   logic [7:0]      bo_q, bo_d;
   logic            brs_q, brs_d;
   logic            init_q, init_d;
   logic            rd_q, rd_d;
   logic [7:0]      asm_byte;

   lcd_bus_sync u_sync (
      .clk     (CCLK),
      .rst_n   (rst_n),
      .lcd_e   (LCDE),
      .lcd_rs  (LCDRS),
      .lcd_rw  (LCDRW),
      .lcd_dat (LCDDAT),
      .strobe  (strobe),
      .rs      (s_rs),
      .rw      (s_rw),
      .dat     (s_dat)
   );

   // Read cycles are observed but never advance the decoder.
   assign bus_wr  = strobe & ~s_rw;
   assign timeout = (cnt_q == CntMax);

   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit8;
         cnt_q   <= '0;
         hi_q    <= '0;
         hi_rs_q <= 1'b0;
         scr_q   <= {NumChars{SPACE}};
         addr_q  <= '0;
         bv_q    <= 1'b0;
         bo_q    <= '0;
         brs_q   <= 1'b0;
         init_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         hi_rs_q <= hi_rs_d;
         scr_q   <= scr_d;
         addr_q  <= addr_d;
         bv_q    <= bv_d;
         bo_q    <= bo_d;
         brs_q   <= brs_d;
         init_q  <= init_d;
         rd_q    <= rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit8: if (bus_wr && !s_rs && s_dat == 4'h2) state_d = StNibHi;
         StNibHi: if (bus_wr) state_d = StNibLo;
         StNibLo: if (bus_wr || timeout) state_d = StNibHi;
         default: state_d = StInit8;
      endcase
   end

   always_comb begin
      cnt_d    = '0;
      hi_d     = hi_q;
      hi_rs_d  = hi_rs_q;
      scr_d    = scr_q;
      addr_d   = addr_q;
      bv_d     = 1'b0;
      bo_d     = bo_q;
      brs_d    = brs_q;
      init_d   = init_q;
      rd_d     = rd_q | (strobe & s_rw);
      asm_byte = {hi_q, s_dat};

      unique case (state_q)
         StInit8: begin
            if (bus_wr && !s_rs && s_dat == 4'h2) init_d = 1'b1;
         end
         StNibHi: begin
            if (bus_wr) begin
               hi_d    = s_dat;
               hi_rs_d = s_rs;
            end
         end
         StNibLo: begin
            // A strobe coinciding with the terminal count still completes the byte.
            if (bus_wr) begin
               bv_d  = 1'b1;
               bo_d  = asm_byte;
               brs_d = hi_rs_q;
               if (hi_rs_q) begin
                  for (int i = 0; i < NumChars; i++) begin
                     if (addr_q == 5'(i)) scr_d[255 - 8*i -: 8] = asm_byte;
                  end
                  addr_d = addr_q + 5'd1;
               end else if (asm_byte == CLEAR) begin
                  scr_d  = {NumChars{SPACE}};
                  addr_d = '0;
               end else if (asm_byte[7:1] == HOME[7:1]) begin
                  addr_d = '0;
               end else if (asm_byte[7:4] == SETADDR_L1[7:4]) begin
                  addr_d = {1'b0, asm_byte[3:0]};
               end else if (asm_byte[7:4] == SETADDR_L2[7:4]) begin
                  addr_d = {1'b1, asm_byte[3:0]};
               end
            end else if (!timeout) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   assign strdata    = scr_q;
   assign byte_valid = bv_q;
   assign byte_out   = bo_q;
   assign byte_rs    = brs_q;
   assign ddram_addr = addr_q;
   assign init_done  = init_q;
   assign rd_seen    = rd_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: drives nibble traffic like the display writer
// and checks the rebuilt screen image and byte reporting.
module tb_lcd_bus_monitor;

   localparam int unsigned TO = 20;

   logic         CCLK = 1'b0;
   logic         rst_n = 1'b0;
   logic         LCDE = 1'b0;
   logic         LCDRS = 1'b0;
   logic         LCDRW = 1'b0;
   logic [3:0]   LCDDAT = 4'h0;
   logic [255:0] strdata;
   logic         byte_valid;
   logic [7:0]   byte_out;
   logic         byte_rs;
   logic [4:0]   ddram_addr;
   logic         init_done;
   logic         rd_seen;

   int total = 0;
   int bad = 0;
   int bv_cnt = 0;

   lcd_bus_monitor #(.TIMEOUT_CYC(TO)) dut (
      .CCLK       (CCLK),
      .rst_n      (rst_n),
      .LCDE       (LCDE),
      .LCDRS      (LCDRS),
      .LCDRW      (LCDRW),
      .LCDDAT     (LCDDAT),
      .strdata    (strdata),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .byte_rs    (byte_rs),
      .ddram_addr (ddram_addr),
      .init_done  (init_done),
      .rd_seen    (rd_seen)
   );

   always #5 CCLK = ~CCLK;

   always @(posedge CCLK) if (byte_valid) bv_cnt <= bv_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
      @(negedge CCLK);
      LCDRS = rs;
      LCDRW = rw;
      LCDDAT = d;
      repeat (4) @(negedge CCLK);
      LCDE = 1'b1;
      repeat (4) @(negedge CCLK);
      LCDE = 1'b0;
      repeat (6) @(negedge CCLK);
   endtask

   task automatic wbyte(input logic rs, input logic [7:0] b);
      nib(rs, 1'b0, b[7:4]);
      nib(rs, 1'b0, b[3:0]);
   endtask

   logic [255:0] spaces;
   logic [255:0] exp_scr;
   logic [255:0] snap;
   int           bv0;

   initial begin
      spaces = {32{8'h20}};

      repeat (3) @(negedge CCLK);
      check("rst_strdata", strdata, spaces);
      check("rst_addr", 256'(ddram_addr), 256'd0);
      check("rst_init", 256'(init_done), 256'd0);
      check("rst_bv", 256'(byte_valid), 256'd0);
      check("rst_rd", 256'(rd_seen), 256'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge CCLK);

      nib(1'b0, 1'b0, 4'h3);
      nib(1'b0, 1'b0, 4'h3);
      nib(1'b0, 1'b0, 4'h3);
      check("init_pending", 256'(init_done), 256'd0);
      nib(1'b0, 1'b0, 4'h2);
      check("init_done", 256'(init_done), 256'd1);
      wbyte(1'b0, 8'h28);
      wbyte(1'b0, 8'h01);
      check("clr_addr", 256'(ddram_addr), 256'd0);
      wbyte(1'b1, 8'h41);
      check("char0_A", 256'(strdata[255:248]), 256'h41);
      check("addr_1", 256'(ddram_addr), 256'd1);
      check("bo_A", 256'(byte_out), 256'h41);
      check("brs_A", 256'(byte_rs), 256'd1);

      wbyte(1'b0, 8'hC5);
      check("addr_c5", 256'(ddram_addr), 256'd21);
      check("brs_cmd", 256'(byte_rs), 256'd0);
      wbyte(1'b1, 8'h5A);
      check("char21_Z", 256'(strdata[87:80]), 256'h5A);
      check("addr_22", 256'(ddram_addr), 256'd22);

      wbyte(1'b0, 8'h8F);
      wbyte(1'b1, 8'h78);
      wbyte(1'b1, 8'h79);
      check("char15_x", 256'(strdata[135:128]), 256'h78);
      check("char16_y", 256'(strdata[127:120]), 256'h79);
      check("addr_17", 256'(ddram_addr), 256'd17);
      wbyte(1'b0, 8'hCF);
      wbyte(1'b1, 8'h70);
      wbyte(1'b1, 8'h71);
      check("char31_p", 256'(strdata[7:0]), 256'h70);
      check("char0_q", 256'(strdata[255:248]), 256'h71);
      check("addr_wrap", 256'(ddram_addr), 256'd1);

      exp_scr = spaces;
      exp_scr[255:248] = 8'h71;
      exp_scr[135:128] = 8'h78;
      exp_scr[127:120] = 8'h79;
      exp_scr[87:80]   = 8'h5A;
      exp_scr[7:0]     = 8'h70;
      check("screen_full", strdata, exp_scr);

      // Orphan high nibble must be discarded after the timeout.
      bv0 = bv_cnt;
      nib(1'b1, 1'b0, 4'h4);
      repeat (TO + 10) @(negedge CCLK);
      nib(1'b1, 1'b0, 4'h4);
      nib(1'b1, 1'b0, 4'h2);
      check("to_bv_count", 256'(bv_cnt - bv0), 256'd1);
      check("to_byte", 256'(byte_out), 256'h42);
      check("to_char1", 256'(strdata[247:240]), 256'h42);
      check("to_addr", 256'(ddram_addr), 256'd2);

      snap = strdata;
      bv0 = bv_cnt;
      nib(1'b1, 1'b1, 4'h5);
      check("rd_seen", 256'(rd_seen), 256'd1);
      check("rd_screen", strdata, snap);
      check("rd_addr", 256'(ddram_addr), 256'd2);
      check("rd_no_byte", 256'(bv_cnt - bv0), 256'd0);
      wbyte(1'b1, 8'h33);
      check("rd_state_kept", 256'(strdata[239:232]), 256'h33);

      // Reset with a high nibble pending.
      nib(1'b1, 1'b0, 4'h6);
      @(negedge CCLK);
      rst_n = 1'b0;
      repeat (2) @(negedge CCLK);
      check("mrst_init", 256'(init_done), 256'd0);
      check("mrst_screen", strdata, spaces);
      check("mrst_addr", 256'(ddram_addr), 256'd0);
      check("mrst_rd", 256'(rd_seen), 256'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge CCLK);
      bv0 = bv_cnt;
      wbyte(1'b1, 8'h41);
      check("init8_rs_ignored", 256'(bv_cnt - bv0), 256'd0);
      check("init8_screen", strdata, spaces);
      nib(1'b0, 1'b0, 4'h2);
      check("reinit_done", 256'(init_done), 256'd1);
      wbyte(1'b1, 8'h55);
      check("reinit_char0", 256'(strdata[255:248]), 256'h55);
      check("reinit_addr", 256'(ddram_addr), 256'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
